// File: rtl/ddr_uart_pkg.sv
// Shared constants and state encoding for the block UART transmitter.
package ddr_uart_pkg;

   // 8N1 frame: one start bit, eight data bits LSB-first, one stop bit
   localparam int DATA_BITS        = 8;
   localparam int START_BITS       = 1;
   localparam int STOP_BITS        = 1;
   localparam int FRAME_BITS       = START_BITS + DATA_BITS + STOP_BITS;

   // 50 MHz / 115200 baud
   localparam int DEF_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 framer. Accepts a byte in IDLE or on the last cycle of STOP,
// so consecutive bytes go out back-to-back with no idle gap.
module uart_tx_byte
   import ddr_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [DATA_BITS-1:0] i_byte,
   input  logic                 i_byte_valid,
   output logic                 o_byte_done,
   output logic                 o_tx
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   state_t               st;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 tx;
   logic                 bit_end;

   assign bit_end     = (clk_cnt == CNT_LAST);
   // high on the final cycle of the stop bit: a new byte offered now starts
   // its start bit on the very next edge
   assign o_byte_done = (st == STOP) && bit_end;
   assign o_tx        = tx;

   // framing FSM: line value is registered and updated at each bit boundary
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         st      <= IDLE;
         tx      <= 1'b1;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (i_byte_valid) begin
                  shreg   <= i_byte;
                  tx      <= 1'b0;
                  clk_cnt <= '0;
                  st      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  tx      <= shreg[0];
                  st      <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     tx <= 1'b1;
                     st <= STOP;
                  end else begin
                     // shreg[0] always holds the bit on the line
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (i_byte_valid) begin
                     shreg <= i_byte;
                     tx    <= 1'b0;
                     st    <= START;
                  end else begin
                     st <= IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               st <= IDLE;
               tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/ddr_uart_block_tx.sv
// Block-level UART transmitter: takes one NUM_BYTES-wide block over valid/ready
// and feeds it byte 0 first into the framer, then pulses o_done for one cycle.
module ddr_uart_block_tx
   import ddr_uart_pkg::*;
#(
   parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter  int NUM_BYTES    = 32,
   localparam int BLK_W        = 8 * NUM_BYTES,
   localparam int IDX_W        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [BLK_W-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_tx_serial,
   output logic             o_busy,
   output logic             o_done,
   output logic [IDX_W-1:0] o_byte_idx
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

   // block-level state: DATA covers the whole time bytes are in flight; the
   // START/DATA/STOP framing detail lives in uart_tx_byte
   state_t           st;
   // holds the bytes not yet handed to the framer, next one in [7:0]
   logic [BLK_W-1:0] shreg;
   logic             accept;
   logic             last_byte;
   logic             byte_valid;
   logic             byte_done;
   logic [7:0]       byte_in;

   assign accept     = (st == IDLE) && i_valid && o_ready;
   assign last_byte  = (o_byte_idx == IDX_LAST);
   assign byte_valid = accept || (byte_done && !last_byte);
   // byte 0 bypasses the register so its start bit begins on the handshake edge
   assign byte_in    = (st == IDLE) ? i_data[7:0] : shreg[7:0];

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_byte       (byte_in),
      .i_byte_valid (byte_valid),
      .o_byte_done  (byte_done),
      .o_tx         (o_tx_serial)
   );

   // block handshake, byte sequencing and the single-cycle DONE pulse
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         st         <= IDLE;
         shreg      <= '0;
         o_byte_idx <= '0;
         o_ready    <= 1'b1;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               o_done <= 1'b0;
               if (accept) begin
                  shreg      <= i_data >> 8;
                  o_byte_idx <= '0;
                  o_ready    <= 1'b0;
                  o_busy     <= 1'b1;
                  st         <= DATA;
               end
            end
            DATA: begin
               if (byte_done) begin
                  if (last_byte) begin
                     o_done <= 1'b1;
                     st     <= DONE;
                  end else begin
                     shreg      <= shreg >> 8;
                     o_byte_idx <= o_byte_idx + 1'b1;
                  end
               end
            end
            DONE: begin
               o_done  <= 1'b0;
               o_ready <= 1'b1;
               o_busy  <= 1'b0;
               st      <= IDLE;
            end
            default: begin
               st      <= IDLE;
               o_ready <= 1'b1;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_uart_block_tx.sv
// Directed bench: decodes the UART line at bit centres for a 32-byte/4-clock
// instance and a 2-byte/1-clock instance.
module tb_ddr_uart_block_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstn;
   logic [255:0] data0;
   logic         valid0, ready0, tx0, busy0, done0;
   logic [4:0]   idx0;
   logic [15:0]  data1;
   logic         valid1, ready1, tx1, busy1, done1;
   logic [0:0]   idx1;

   int checks = 0;
   int errors = 0;
   int dcnt0 = 0;
   int dcnt1 = 0;
   int dstart;
   int waits;
   int cpre;
   logic [7:0] exp_b [32];

   ddr_uart_block_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(32)) dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_data(data0), .i_valid(valid0), .o_ready(ready0),
      .o_tx_serial(tx0), .o_busy(busy0), .o_done(done0), .o_byte_idx(idx0));

   ddr_uart_block_tx #(.CLKS_PER_BIT(1), .NUM_BYTES(2)) dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_data(data1), .i_valid(valid1), .o_ready(ready1),
      .o_tx_serial(tx1), .o_busy(busy1), .o_done(done1), .o_byte_idx(idx1));

   // count o_done pulses independently of the reset
   always @(posedge clk) begin
      if (done0 === 1'b1) dcnt0 <= dcnt0 + 1;
      if (done1 === 1'b1) dcnt1 <= dcnt1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns just after the handshake posedge
   task automatic hs(input int sel, output int w);
      w = 0;
      if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
      while (((sel == 0) ? ready0 : ready1) !== 1'b1 && w < 20000) begin
         @(negedge clk);
         w++;
      end
      chk("hs_ready", (sel == 0) ? ready0 : ready1, 1);
      dstart = (sel == 0) ? dcnt0 : dcnt1;
      @(posedge clk);
   endtask

   // called right after the handshake posedge; ends at the negedge one cycle after o_done
   task automatic decode(input int sel, input int cpb, input int nb, input bit drop_v, input bit chg);
      int rel = 0;
      int off;
      logic line;
      logic [7:0] b = '0;
      for (int f = 0; f < nb; f++) begin
         for (int j = 0; j < 10; j++) begin
            off = (f * 10 + j) * cpb + (cpb - 1) / 2;
            repeat (off - rel) @(posedge clk);
            rel = off;
            @(negedge clk);
            line = (sel == 0) ? tx0 : tx1;
            if (f == 0 && j == 0) begin
               if (drop_v) begin valid0 = 1'b0; valid1 = 1'b0; end
               if (chg) data0 = {32{8'hA5}};
            end
            if (j == 0) chk("start_bit", line, 0);
            else if (j == 9) chk("stop_bit", line, 1);
            else b[j-1] = line;
            if (j == 5) begin
               chk("byte_idx", (sel == 0) ? idx0 : idx1, f);
               chk("busy_mid", (sel == 0) ? busy0 : busy1, 1);
            end
         end
         chk("byte_val", b, exp_b[f]);
      end
      repeat (nb * 10 * cpb - rel) @(posedge clk);
      @(negedge clk);
      chk("done_hi",    (sel == 0) ? done0 : done1, 1);
      chk("done_early", (sel == 0) ? dcnt0 : dcnt1, dstart);
      chk("done_ready", (sel == 0) ? ready0 : ready1, 0);
      chk("done_line",  (sel == 0) ? tx0 : tx1, 1);
      @(posedge clk);
      @(negedge clk);
      chk("done_lo",    (sel == 0) ? done0 : done1, 0);
      chk("done_once",  (sel == 0) ? dcnt0 : dcnt1, dstart + 1);
      chk("idle_ready", (sel == 0) ? ready0 : ready1, 1);
      chk("idle_busy",  (sel == 0) ? busy0 : busy1, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
      // 1. reset and idle
      #12;
      chk("rst_tx", tx0, 1);
      chk("rst_ready", ready0, 1);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_idx", idx0, 0);
      chk("rst_tx1", tx1, 1);
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_tx", tx0, 1);
      chk("idle_rdy", ready0, 1);
      chk("idle_bsy", busy0, 0);

      // 2. single block, byte k = k
      for (int k = 0; k < 32; k++) begin data0[8*k +: 8] = 8'(k); exp_b[k] = 8'(k); end
      hs(0, waits);
      decode(0, 4, 32, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("no_reaccept", busy0, 0);

      // 3. valid held, data changed mid-block
      hs(0, waits);
      decode(0, 4, 32, 1'b0, 1'b1);
      for (int k = 0; k < 32; k++) exp_b[k] = 8'hA5;
      hs(0, waits);
      chk("b2b_gap", waits, 0);
      decode(0, 4, 32, 1'b1, 1'b0);

      // 4. reset during data bit 3 of byte 5 (0x05: bit 3 is 0)
      for (int k = 0; k < 32; k++) data0[8*k +: 8] = 8'(k);
      hs(0, waits);
      @(negedge clk); valid0 = 1'b0;
      repeat (54 * 4 + 1) @(posedge clk);
      @(negedge clk);
      chk("mid_line", tx0, 0);
      chk("mid_idx", idx0, 5);
      cpre = dcnt0;
      #1 rstn = 1'b0;
      #1;
      chk("arst_tx", tx0, 1);
      chk("arst_ready", ready0, 1);
      chk("arst_busy", busy0, 0);
      chk("arst_idx", idx0, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rel_ready", ready0, 1);
      repeat (30) @(negedge clk);
      chk("rst_no_done", dcnt0, cpre);
      chk("rel_tx", tx0, 1);
      data0 = {32{8'h3C}};
      for (int k = 0; k < 32; k++) exp_b[k] = 8'h3C;
      hs(0, waits);
      decode(0, 4, 32, 1'b1, 1'b0);

      // 5. data extremes
      data0 = '0;
      for (int k = 0; k < 32; k++) exp_b[k] = 8'h00;
      hs(0, waits);
      decode(0, 4, 32, 1'b1, 1'b0);
      data0 = '1;
      for (int k = 0; k < 32; k++) exp_b[k] = 8'hFF;
      hs(0, waits);
      decode(0, 4, 32, 1'b1, 1'b0);

      // 6. one clock per bit, two bytes
      data1 = 16'hC35A;
      exp_b[0] = 8'h5A;
      exp_b[1] = 8'hC3;
      hs(1, waits);
      decode(1, 1, 2, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
